// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning slice.
// Button order on the board: next, hit, stand, double.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_NEXT   = 0;
  localparam int BTN_HIT    = 1;
  localparam int BTN_STAND  = 2;
  localparam int BTN_DOUBLE = 3;
  localparam int BTN_COUNT  = 4;

endpackage

// File: rtl/btn_debounce_fsm.sv
// Single-button conditioner: SYNC_STAGES-deep synchroniser, saturating
// debounce counter and a four-state FSM producing a one-cycle press pulse
// and a clean level. Resets into RELEASE_WAIT so a button held through
// reset never fires and no press is accepted right after reset.
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_t             state;
  logic [CW-1:0]          cnt;

  // Metastability synchroniser; only the last stage is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM. The counter stops at CNT_LAST (the transition fires there),
  // so it never wraps. The level register only changes on entry to HELD or
  // IDLE: it stays low through the post-reset release wait of a button that
  // was never seen pressed, and stays high through release bounces.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RELEASE_WAIT;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASE_WAIT;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board buttons (next, hit, stand, double) into one-clock
// press events plus debounced levels for the game core and display logic.
// Optional macro BTN_PRIORITY_EN: adds a registered arbitration stage that
// forwards only the lowest-index coincident pulse and flags drops on
// btn_conflict; pulse and level both gain one cycle of latency.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = BTN_COUNT,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic             btn_busy
`ifdef BTN_PRIORITY_EN
  ,
  output logic             btn_conflict
`endif
);

  logic [N_BTN-1:0] fsm_pulse;
  logic [N_BTN-1:0] fsm_level;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_fsm (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .pulse  (fsm_pulse[i]),
      .level  (fsm_level[i])
    );
  end

`ifdef BTN_PRIORITY_EN
  // Arbitration: x & -x isolates the lowest set pulse; x & (x-1) is nonzero
  // when more than one pulse coincides. Dropped pulses are not deferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_pulse    <= '0;
      btn_level    <= '0;
      btn_conflict <= 1'b0;
    end else begin
      btn_pulse    <= fsm_pulse & (~fsm_pulse + N_BTN'(1));
      btn_conflict <= |(fsm_pulse & (fsm_pulse - N_BTN'(1)));
      btn_level    <= fsm_level;
    end
  end
`else
  assign btn_pulse = fsm_pulse;
  assign btn_level = fsm_level;
`endif

  assign btn_busy = |btn_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
// with a run-length behavioural model checked every cycle.
module tb_button_conditioner;

  localparam int N = 4;
  localparam int D = 4;
  localparam int S = 2;
`ifdef BTN_PRIORITY_EN
  localparam int P = 1;
  localparam logic [3:0] COINC = 4'b0010;
`else
  localparam int P = 0;
  localparam logic [3:0] COINC = 4'b1010;
`endif
  localparam int LAT = 7 + P;   // S + D + 1, plus arbitration stage

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_pulse, btn_level;
  logic         btn_busy;
`ifdef BTN_PRIORITY_EN
  logic         btn_conflict;
`endif

  int n_chk = 0;
  int n_fail = 0;

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .btn_busy (btn_busy)
`ifdef BTN_PRIORITY_EN
    ,
    .btn_conflict(btn_conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A press is accepted after D+1 consecutive synced-high samples while the
  // button is known released; a release after D+1 consecutive low samples
  // (only D right after reset, where no debounced press was ever seen).
  int           hi_run[N];
  int           lo_run[N];
  bit           armed[N];
  bit           fresh[N];
  bit           lvl[N];
  bit           sq[N][S];
  logic [N-1:0] m_p, m_l;
  logic [N-1:0] exp_pulse, exp_level;
  logic         exp_conf;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        hi_run[i] = 0; lo_run[i] = 0; armed[i] = 0; fresh[i] = 1; lvl[i] = 0;
        for (int j = 0; j < S; j++) sq[i][j] = 0;
      end
      m_p = '0; m_l = '0; exp_pulse = '0; exp_level = '0; exp_conf = 1'b0;
    end else begin
`ifdef BTN_PRIORITY_EN
      begin
        int cnt1;
        cnt1 = 0;
        exp_pulse = '0;
        for (int i = N - 1; i >= 0; i--) if (m_p[i]) begin exp_pulse = '0; exp_pulse[i] = 1'b1; cnt1++; end
        exp_conf  = (cnt1 > 1);
        exp_level = m_l;
      end
`endif
      for (int i = 0; i < N; i++) begin
        bit sv;
        sv = sq[i][S-1];
        m_p[i] = 1'b0;
        if (sv) begin if (hi_run[i] < 1000) hi_run[i]++; lo_run[i] = 0; end
        else    begin if (lo_run[i] < 1000) lo_run[i]++; hi_run[i] = 0; end
        if (armed[i]) begin
          if (sv && hi_run[i] == D + 1) begin
            m_p[i] = 1'b1; armed[i] = 0; lvl[i] = 1; fresh[i] = 0;
          end
        end else begin
          if (sv) begin fresh[i] = 0; lvl[i] = 1; end
          else if (lo_run[i] == (fresh[i] ? D : D + 1)) begin armed[i] = 1; lvl[i] = 0; end
        end
        m_l[i] = lvl[i];
        for (int j = S - 1; j > 0; j--) sq[i][j] = sq[i][j-1];
        sq[i][0] = btn_raw[i];
      end
`ifndef BTN_PRIORITY_EN
      exp_pulse = m_p;
      exp_level = m_l;
      exp_conf  = 1'b0;
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("cyc_pulse", 32'(btn_pulse), 32'(exp_pulse));
    chk("cyc_level", 32'(btn_level), 32'(exp_level));
    chk("cyc_busy", 32'(btn_busy), 32'(|exp_level));
`ifdef BTN_PRIORITY_EN
    chk("cyc_conflict", 32'(btn_conflict), 32'(exp_conf));
`else
    if (exp_conf) chk("cyc_conflict_model", 32'(exp_conf), 32'd0);
`endif
  end

  // Watch button b for ncyc negedges (k=1 is the first negedge after the
  // edge that samples the last input change).
  task automatic run(input int ncyc, input int b, output int fk, output int np,
                     output int np_any, output int fhi, output int flo, output int nlow);
    fk = -1; np = 0; np_any = 0; fhi = -1; flo = -1; nlow = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (btn_pulse[b]) begin np++; if (fk < 0) fk = k; end
      if (btn_pulse != '0) np_any++;
      if (btn_level[b]) begin if (fhi < 0) fhi = k; end
      else begin nlow++; if (flo < 0) flo = k; end
    end
  endtask

  int fk, np, npa, fhi, flo, nlow, acc;
  logic [3:0] pat;
  logic [8:0] tog;

  initial begin
    // T0: reset state
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulse", 32'(btn_pulse), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_busy", 32'(btn_busy), 32'd0);
    reset = 1'b1;
    run(10, 0, fk, np, npa, fhi, flo, nlow);
    chk("post_rst_nopulse", npa, 0);

    // T1: clean press of hit, held 50 cycles, then release
    btn_raw[1] = 1'b1;
    run(50, 1, fk, np, npa, fhi, flo, nlow);
    chk("t1_pulse_cycle", fk, LAT);
    chk("t1_pulse_count", np, 1);
    chk("t1_level_rise", fhi, LAT);
    btn_raw[1] = 1'b0;
    run(20, 1, fk, np, npa, fhi, flo, nlow);
    chk("t1_level_fall", flo, LAT);
    chk("t1_release_nopulse", np, 0);

    // T2: 3-cycle glitch on next, then toggle pattern, then a clean hold
    btn_raw[0] = 1'b1;
    run(3, 0, fk, np, npa, fhi, flo, nlow);
    acc = np;
    btn_raw[0] = 1'b0;
    run(15, 0, fk, np, npa, fhi, flo, nlow);
    chk("t2_glitch_nopulse", acc + np, 0);
    chk("t2_glitch_level", fhi, -1);
    tog = 9'b011101101;   // applied LSB first: 1,0,1,1,0,1,1,1,0
    acc = 0;
    for (int j = 0; j < 9; j++) begin
      btn_raw[0] = tog[j];
      @(negedge clk);
      if (btn_pulse[0]) acc++;
    end
    btn_raw[0] = 1'b1;
    run(20, 0, fk, np, npa, fhi, flo, nlow);
    chk("t2_toggle_pulse_cycle", fk, LAT);
    chk("t2_toggle_count", acc + np, 1);
    btn_raw[0] = 1'b0;
    run(15, 0, fk, np, npa, fhi, flo, nlow);

    // T3: stand held through reset -> no pulse; release and press again
    btn_raw[2] = 1'b1;
    run(5, 2, fk, np, npa, fhi, flo, nlow);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run(100, 2, fk, np, npa, fhi, flo, nlow);
    chk("t3_held_nopulse", npa, 0);
    chk("t3_held_level_rise", fhi, S + 1 + P);
    chk("t3_held_level_last", 32'(btn_level[2]), 32'd1);
    btn_raw[2] = 1'b0;
    run(15, 2, fk, np, npa, fhi, flo, nlow);
    btn_raw[2] = 1'b1;
    run(20, 2, fk, np, npa, fhi, flo, nlow);
    chk("t3_repress_count", np, 1);
    chk("t3_repress_cycle", fk, LAT);
    btn_raw[2] = 1'b0;
    run(15, 2, fk, np, npa, fhi, flo, nlow);

    // T4: async reset mid-PRESS_WAIT on double while hit is held
    btn_raw[1] = 1'b1;
    run(20, 1, fk, np, npa, fhi, flo, nlow);
    btn_raw[3] = 1'b1;
    run(4, 3, fk, np, npa, fhi, flo, nlow);
    chk("t4_pre_level", 32'(btn_level), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_level", 32'(btn_level), 32'd0);
    chk("t4_async_pulse", 32'(btn_pulse), 32'd0);
    chk("t4_async_busy", 32'(btn_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(30, 3, fk, np, npa, fhi, flo, nlow);
    chk("t4_after_rst_nopulse", npa, 0);
    btn_raw = '0;
    run(15, 3, fk, np, npa, fhi, flo, nlow);
    btn_raw[3] = 1'b1;
    run(20, 3, fk, np, npa, fhi, flo, nlow);
    chk("t4_new_press_cycle", fk, LAT);
    btn_raw[3] = 1'b0;
    run(15, 3, fk, np, npa, fhi, flo, nlow);

    // T5: hit and double pressed on the same cycle
    btn_raw[1] = 1'b1;
    btn_raw[3] = 1'b1;
    fk = -1; acc = 0; pat = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (btn_pulse != '0) begin
        acc++;
        if (fk < 0) begin
          fk = k; pat = btn_pulse;
`ifdef BTN_PRIORITY_EN
          chk("t5_conflict", 32'(btn_conflict), 32'd1);
`endif
        end
      end
    end
    chk("t5_coinc_cycle", fk, LAT);
    chk("t5_coinc_value", 32'(pat), 32'(COINC));
    chk("t5_coinc_count", acc, 1);

    // T6: bounce on release of hit while in RELEASE_WAIT
    btn_raw[1] = 1'b0;
    run(2, 1, fk, np, npa, fhi, flo, nlow);
    acc = nlow + npa;
    btn_raw[1] = 1'b1;
    run(20, 1, fk, np, npa, fhi, flo, nlow);
    chk("t6_bounce_level_low", acc + nlow, 0);
    chk("t6_bounce_nopulse", npa, 0);
    btn_raw = '0;
    run(15, 1, fk, np, npa, fhi, flo, nlow);
    chk("t6_final_level", 32'(btn_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
